ifu: RTL and testbench

Instruction fetch unit for the multi-cycle NPC core. Holds the architectural PC, issues one instruction-memory read per instruction over a valid/ready request channel, and presents the fetched word to decode with a valid/ready handshake. It waits for the write-back stage to retire the instruction, then loads the `next_pc` that write-back computes and starts the next fetch.

---
 rtl/ifu.sv | 104 ++++++++++
 tb/tb_ifu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction from
// instruction memory, hands it to decode and waits for write-back to retire it.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        wb_done,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault,
    output logic [31:0] inst_cnt,
    output logic [2:0]  fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never depends on ready and holds with its payload until
    // the transfer.

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_EXEC = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;

    assign imem_req_addr = pc;
    assign fsm_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_BOOT;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= 32'd0;
            inst_pc        <= 32'd0;
            fetch_fault    <= 1'b0;
            inst_cnt       <= 32'd0;
        end else begin
            case (state)
                S_BOOT: begin
                    state          <= S_REQ;
                    imem_req_valid <= (pc[1:0] == 2'b00);
                end
                S_REQ: begin
                    // A misaligned PC never reaches memory; decode sees a fault.
                    if (pc[1:0] != 2'b00) begin
                        inst        <= 32'd0;
                        fetch_fault <= 1'b1;
                        inst_pc     <= pc;
                        inst_valid  <= 1'b1;
                        state       <= S_HOLD;
                    end else if (imem_req_valid && imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        inst        <= imem_resp_data;
                        fetch_fault <= imem_resp_err;
                        inst_pc     <= pc;
                        inst_valid  <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_valid && inst_ready) begin
                        inst_valid <= 1'b0;
                        inst_cnt   <= inst_cnt + 32'd1;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (wb_done) begin
                        pc             <= next_pc;
                        imem_req_valid <= (next_pc[1:0] == 2'b00);
                        state          <= S_REQ;
                    end
                end
                default: begin
                    state          <= S_BOOT;
                    imem_req_valid <= 1'b0;
                    inst_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a cycle table of inputs and expected outputs, then
// hand-written sequences for asynchronous reset and counter wrap.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        wb_done;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic [31:0] inst_cnt;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .next_pc         (next_pc),
        .wb_done         (wb_done),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault),
        .inst_cnt        (inst_cnt),
        .fsm_state       (fsm_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) hs_cnt++;
    end

    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        re;
        logic        ir;
        logic        wb;
        logic [31:0] npc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_ff;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mk(logic rr, logic rv, logic [31:0] rd, logic re,
                                logic ir, logic wb, logic [31:0] npc,
                                logic e_rv, logic [31:0] e_addr, logic e_iv,
                                logic [31:0] e_inst, logic [31:0] e_ipc,
                                logic e_ff, logic [31:0] e_cnt);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rd = rd; v.re = re; v.ir = ir; v.wb = wb;
        v.npc = npc; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_ff = e_ff; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_rv, input logic [31:0] e_addr,
                           input logic e_iv, input logic [31:0] e_inst,
                           input logic [31:0] e_ipc, input logic e_ff,
                           input logic [31:0] e_cnt);
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rv});
        chk({tag, ".req_addr"}, imem_req_addr, e_addr);
        chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_iv});
        chk({tag, ".inst"}, inst, e_inst);
        chk({tag, ".inst_pc"}, inst_pc, e_ipc);
        chk({tag, ".fetch_fault"}, {31'd0, fetch_fault}, {31'd0, e_ff});
        chk({tag, ".inst_cnt"}, inst_cnt, e_cnt);
    endtask

    task automatic drive_idle();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        imem_resp_err   = 1'b0;
        inst_ready      = 1'b0;
        wb_done         = 1'b0;
        next_pc         = 32'd0;
    endtask

    localparam logic [31:0] A = 32'h8000_0000;
    localparam logic [31:0] B = 32'h8000_0100;
    localparam logic [31:0] M = 32'h8000_0102;
    localparam logic [31:0] C = 32'h8000_0200;

    initial begin
        // Row i: outputs expected during cycle i, and inputs applied in cycle i.
        vecs[0]  = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         0, A, 0, 32'h0,   32'h0, 0, 0);
        vecs[1]  = mk(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         1, A, 0, 32'h0,   32'h0, 0, 0);
        vecs[2]  = mk(0, 1, 32'h0000_0413, 0, 0, 1, 32'h1234_5678, 0, A, 0, 32'h0,   32'h0, 0, 0);
        vecs[3]  = mk(0, 0, 32'h0,         0, 1, 1, 32'h2222_0000, 0, A, 1, 32'h413, A,     0, 0);
        vecs[4]  = mk(0, 1, 32'hFFFF_FFFF, 1, 0, 0, 32'h0,         0, A, 0, 32'h413, A,     0, 1);
        vecs[5]  = mk(0, 0, 32'h0,         0, 0, 1, B,             0, A, 0, 32'h413, A,     0, 1);
        vecs[6]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, B, 0, 32'h413, A,     0, 1);
        vecs[7]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, B, 0, 32'h413, A,     0, 1);
        vecs[8]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, B, 0, 32'h413, A,     0, 1);
        vecs[9]  = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, B, 0, 32'h413, A,     0, 1);
        vecs[10] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, B, 0, 32'h413, A,     0, 1);
        vecs[11] = mk(0, 1, 32'h0000_0093, 1, 0, 0, 32'h0,         0, B, 0, 32'h413, A,     0, 1);
        vecs[12] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, B, 1, 32'h93,  B,     1, 1);
        vecs[13] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, B, 1, 32'h93,  B,     1, 1);
        vecs[14] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, B, 1, 32'h93,  B,     1, 1);
        vecs[15] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, B, 1, 32'h93,  B,     1, 1);
        vecs[16] = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,         0, B, 1, 32'h93,  B,     1, 1);
        vecs[17] = mk(0, 0, 32'h0,         0, 0, 1, M,             0, B, 0, 32'h93,  B,     1, 2);
        vecs[18] = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         0, M, 0, 32'h93,  B,     1, 2);
        vecs[19] = mk(1, 0, 32'h0,         0, 1, 0, 32'h0,         0, M, 1, 32'h0,   M,     1, 2);
        vecs[20] = mk(0, 0, 32'h0,         0, 0, 1, C,             0, M, 0, 32'h0,   M,     1, 3);
        vecs[21] = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, C, 0, 32'h0,   M,     1, 3);
        vecs[22] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, C, 0, 32'h0,   M,     1, 3);

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        chk_all("reset", 0, A, 0, 32'h0, 32'h0, 0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            chk_all($sformatf("row%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv,
                    vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_ff, vecs[i].e_cnt);
            imem_req_ready  = vecs[i].rr;
            imem_resp_valid = vecs[i].rv;
            imem_resp_data  = vecs[i].rd;
            imem_resp_err   = vecs[i].re;
            inst_ready      = vecs[i].ir;
            wb_done         = vecs[i].wb;
            next_pc         = vecs[i].npc;
            @(negedge clk);
        end
        chk("req_handshakes", hs_cnt, 32'd3);

        // Unit now sits in WAIT; reset between clock edges must act at once.
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 0, A, 0, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0BAD_0BAD;
        chk("post_reset.req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        chk("post_reset.req_valid2", {31'd0, imem_req_valid}, 32'd1);
        chk("post_reset.req_addr", imem_req_addr, A);
        chk("post_reset.inst_valid", {31'd0, inst_valid}, 32'd0);
        imem_resp_valid = 1'b0;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0013;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        chk_all("post_reset.fetch", 0, A, 1, 32'h13, A, 0, 32'h0);

        // Counter wrap: preload all-ones, then accept one instruction.
        force dut.inst_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.inst_cnt;
        chk("wrap.preload", inst_cnt, 32'hFFFF_FFFF);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("wrap.inst_cnt", inst_cnt, 32'h0);
        chk("wrap.inst_valid", {31'd0, inst_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
